// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative RV32M multiply/divide sequencer for the EX stage.
// Ports: clock, reset (async active-low); start/kill/funct3/op_a/op_b from ID/EX;
// stall_req holds the front of the pipeline; busy = not IDLE; done pulses with result valid.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] f3_q, f3_d;
    logic neg_q, neg_d;
    logic [WIDTH-1:0] b_q, b_d, res_q, res_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] abs_a, abs_b, quo, rem, fix_res;
    logic [WIDTH:0] mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    assign a_neg    = op_a[WIDTH-1] & (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    assign b_neg    = op_b[WIDTH-1] & (funct3 inside {3'b001, 3'b100, 3'b110});
    assign abs_a    = a_neg ? -op_a : op_a;
    assign abs_b    = b_neg ? -op_b : op_b;
    assign div_zero = funct3[2] & (op_b == '0);
    assign ovf      = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b == '1);
    // Multiply: {hi, lo} with lo holding the unconsumed multiplier bits.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: {remainder, dividend/quotient}; trial subtract on the shifted remainder.
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    // Remainder takes the dividend sign, so neg_q already encodes the right flag per op.
    assign prod     = neg_q ? -acc_q : acc_q;
    assign quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem      = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign fix_res  = f3_q[2] ? (f3_q[1] ? rem : quo)
                              : (f3_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
`ifdef MULDIV_FAST_MUL_EN
    logic [WIDTH:0] fa, fb;
    logic [2*WIDTH-1:0] fast_p;
    assign fa     = {op_a[WIDTH-1] & (funct3 inside {3'b001, 3'b010}), op_a};
    assign fb     = {op_b[WIDTH-1] & (funct3 == 3'b001), op_b};
    assign fast_p = {{(WIDTH-1){fa[WIDTH]}}, fa} * {{(WIDTH-1){fb[WIDTH]}}, fb};
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start && !kill) begin
                f3_d    = funct3;
                neg_d   = a_neg ^ (b_neg & ~funct3[1]);
                b_d     = abs_b;
                acc_d   = {{WIDTH{1'b0}}, abs_a};
                cnt_d   = '0;
                state_d = CALC;
                if (div_zero) begin
                    res_d   = funct3[1] ? op_a : '1;
                    state_d = DONE;
                end else if (ovf) begin
                    res_d   = funct3[1] ? '0 : op_a;
                    state_d = DONE;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!funct3[2]) begin
                    res_d   = funct3 == 3'b000 ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
                    state_d = DONE;
                end
`endif
            end
            CALC: if (kill) state_d = IDLE;
            else begin
                acc_d   = f3_q[2] ? div_next : mul_next;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CNT_W'(WIDTH-1) ? FIX : CALC;
            end
            FIX: if (kill) state_d = IDLE;
            else begin
                res_d   = fix_res;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end
    assign stall_req = reset & (((state_q == IDLE) & start & ~kill) | (state_q == CALC) | (state_q == FIX));
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign result    = res_q;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: random and directed checks of ex_muldiv_sequencer against an arithmetic model.
module tb_ex_muldiv_sequencer;
    logic clock = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0, result;
    logic stall_req, busy, done;
    int n_tests = 0, n_fail = 0;
    logic [31:0] last_res;
    ex_muldiv_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic sovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : sovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : sovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction
    function automatic int exp_stalls(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 34;
    endfunction
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep);
        int stalls = 0, dones = 0;
        logic [31:0] got = 'x;
        @(negedge clock);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1 chk("idle_done", 32'(done), 32'd0);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) #1;
            if (stall_req) stalls++;
            if (done) begin got = result; dones++; break; end
            @(negedge clock);
        end
        if (!keep) start = 1'b0;
        chk($sformatf("res f%0d %h %h", f, a, b), got, model(f, a, b));
        chk($sformatf("stall f%0d", f), 32'(stalls), 32'(exp_stalls(f, a, b)));
        chk("done_seen", 32'(dones), 32'd1);
        last_res = got;
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int dcount;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_result", result, 0);
        @(negedge clock);
        reset = 1'b1;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);     chk("tp_mul", last_res, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); chk("tp_mulhu", last_res, 32'hFFFF_FFFE);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0); chk("tp_mulh", last_res, 32'h4000_0000);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);     chk("tp_div", last_res, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);     chk("tp_rem", last_res, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 0);           chk("tp_divu", last_res, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 0);           chk("tp_remu", last_res, 32'd2);
        run_op(3'd5, 32'd5, 32'd0, 0);             chk("tp_divu0", last_res, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd7, 32'd0, 0);             chk("tp_rem0", last_res, 32'd7);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0); chk("tp_divovf", last_res, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0); chk("tp_removf", last_res, 32'h0);
        // start held through DONE, next instruction presented right after
        run_op(3'd5, 32'd1000, 32'd10, 1);         chk("b2b_first", last_res, 32'd100);
        run_op(3'd4, 32'hFFFF_FF00, 32'd16, 0);    chk("b2b_second", last_res, 32'hFFFF_FFF0);
        // kill at counter 10
        @(negedge clock);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        repeat (11) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0; start = 1'b0;
        #1;
        chk("kill_busy", 32'(busy), 0);
        chk("kill_stall", 32'(stall_req), 0);
        chk("kill_result", result, 32'hFFFF_FFF0);
        dcount = 0;
        repeat (40) begin @(negedge clock); #1 if (done) dcount++; end
        chk("kill_nodone", 32'(dcount), 0);
        // asynchronous reset at counter 20
        @(negedge clock);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        repeat (21) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_stall", 32'(stall_req), 0);
        chk("arst_result", result, 0);
        @(negedge clock);
        start = 1'b0; reset = 1'b1;
        for (int i = 0; i < 150; i++) run_op(3'($urandom_range(0, 7)), pick(), pick(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
